// File: rtl/inst_fetch_unit.sv
// IF-stage fetch unit: owns the PC, drives the synchronous instruction memory
// and presents PC-tagged instructions to IF/ID with a one-deep stall buffer.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] InstAddr,
  input  logic [31:0] Instruction,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_STREAM = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] pc_inc;
  state_t      state;

  // Low target bits are dropped: fetches are always word aligned.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

  assign InstAddr = fetch_pc_q;
  assign pc_inc   = fetch_pc_q + 32'd4;

  assign if_valid = hold_valid_q | resp_valid_q;
  assign if_pc    = hold_valid_q ? hold_pc_q   : resp_pc_q;
  assign if_inst  = hold_valid_q ? hold_inst_q : Instruction;

  always_comb begin
    state = S_EMPTY;
    if (hold_valid_q)
      state = S_HOLD;
    else if (resp_valid_q)
      state = S_STREAM;
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_inst_d  = hold_inst_q;
    hold_valid_d = hold_valid_q;
    if (redirect_valid) begin
      // The read already in flight belongs to the old path: squash it.
      fetch_pc_d   = {redirect_pc[31:2], 2'b00};
      resp_valid_d = 1'b0;
      hold_valid_d = 1'b0;
    end else begin
      unique case (state)
        S_EMPTY: begin
          resp_pc_d    = fetch_pc_q;
          resp_valid_d = 1'b1;
          fetch_pc_d   = pc_inc;
        end
        S_STREAM: begin
          resp_pc_d    = fetch_pc_q;
          resp_valid_d = 1'b1;
          if (stall) begin
            hold_pc_d    = resp_pc_q;
            hold_inst_d  = Instruction;
            hold_valid_d = 1'b1;
          end else begin
            fetch_pc_d = pc_inc;
          end
        end
        S_HOLD: begin
          // Memory keeps re-reading fetch_pc so its data is ready on release.
          resp_pc_d    = fetch_pc_q;
          resp_valid_d = 1'b1;
          if (!stall) begin
            hold_valid_d = 1'b0;
            fetch_pc_d   = pc_inc;
          end
        end
        default: begin
          resp_valid_d = 1'b0;
          hold_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= 32'h0;
      resp_valid_q <= 1'b0;
      hold_pc_q    <= 32'h0;
      hold_inst_q  <= 32'h0;
      hold_valid_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_inst_q  <= hold_inst_d;
      hold_valid_q <= hold_valid_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios then random stall/redirect/reset
// traffic, checked against a transaction-level model of the presented stream.
module tb_inst_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstAddr;
  logic [31:0] Instruction;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int tests = 0;
  int fails = 0;

  // Model: the PC that is (or will be) presented, and whether it is visible.
  logic        m_known = 1'b0;
  logic        m_valid;
  logic [31:0] m_pc;

  inst_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rst(rst),
    .InstAddr(InstAddr),
    .Instruction(Instruction),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: mem[a>>2] = A000_0000 | a.
  always @(posedge clk) Instruction <= 32'hA000_0000 | InstAddr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("if_pc", if_pc, m_pc);
      chk("if_inst", if_inst, 32'hA000_0000 | m_pc);
      chk("addr_stream", InstAddr, m_pc + 32'd4);
    end else begin
      chk("addr_empty", InstAddr, m_pc);
    end
  endtask

  // One clock: drive inputs at negedge, check, then advance model at posedge.
  task automatic cyc(input logic r, input logic s, input logic rv,
                     input logic [31:0] rp);
    rst = r;
    stall = s;
    redirect_valid = rv;
    redirect_pc = rp;
    #1;
    if (m_known) check_model();
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0;
      m_pc = RST_PC;
      m_known = 1'b1;
    end else if (rv) begin
      m_valid = 1'b0;
      m_pc = {rp[31:2], 2'b00};
    end else if (!m_valid) begin
      m_valid = 1'b1;
    end else if (!s) begin
      m_pc = m_pc + 32'd4;
    end
    @(negedge clk);
  endtask

  task automatic chk_pres(input string tag, input logic v,
                          input logic [31:0] pc);
    #1;
    chk({tag, "_v"}, {31'b0, if_valid}, {31'b0, v});
    if (v) chk({tag, "_pc"}, if_pc, pc);
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    // 1: reset release and plain streaming
    cyc(1, 0, 0, 0);
    chk_pres("t1_c0", 0, 0);
    chk("t1_addr0", InstAddr, RST_PC);
    cyc(0, 0, 0, 0);
    chk_pres("t1_c1", 1, 32'h0);
    chk("t1_inst0", if_inst, 32'hA000_0000);
    cyc(0, 0, 0, 0);
    chk_pres("t1_c2", 1, 32'h4);
    cyc(0, 0, 0, 0);
    chk_pres("t1_c3", 1, 32'h8);

    // 2: three stalled cycles on 0x8, then release
    cyc(0, 1, 0, 0);
    chk_pres("t2_h1", 1, 32'h8);
    chk("t2_addr", InstAddr, 32'hC);
    cyc(0, 1, 0, 0);
    chk_pres("t2_h2", 1, 32'h8);
    cyc(0, 1, 0, 0);
    chk_pres("t2_h3", 1, 32'h8);
    chk("t2_inst", if_inst, 32'hA000_0008);
    cyc(0, 0, 0, 0);
    chk_pres("t2_rel", 1, 32'hC);
    cyc(0, 0, 0, 0);
    chk_pres("t2_next", 1, 32'h10);

    // 3: redirect to 0x40 while presenting 0x10
    cyc(0, 0, 1, 32'h40);
    chk_pres("t3_bub", 0, 0);
    cyc(0, 0, 0, 0);
    chk_pres("t3_a", 1, 32'h40);
    cyc(0, 0, 0, 0);
    chk_pres("t3_b", 1, 32'h44);
    cyc(0, 0, 0, 0);
    chk_pres("t3_c", 1, 32'h48);

    // 4: redirect with stall while in HOLD
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'h80);
    chk_pres("t4_bub", 0, 0);
    cyc(0, 1, 0, 0);
    chk_pres("t4_h1", 1, 32'h80);
    cyc(0, 1, 0, 0);
    chk_pres("t4_h2", 1, 32'h80);
    cyc(0, 0, 0, 0);
    chk_pres("t4_rel", 1, 32'h84);

    // 5: reset during HOLD
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk_pres("t5_rst", 0, 0);
    chk("t5_addr", InstAddr, RST_PC);
    cyc(0, 0, 0, 0);
    chk_pres("t5_a", 1, 32'h0);
    cyc(0, 0, 0, 0);
    chk_pres("t5_b", 1, 32'h4);

    // 6: misaligned redirect near the top of the address space
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'hFFFF_FFFE);
    chk_pres("t6_bub", 0, 0);
    chk("t6_addr", InstAddr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk_pres("t6_a", 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk_pres("t6_wrap", 1, 32'h0);
    cyc(0, 0, 0, 0);
    chk_pres("t6_c", 1, 32'h4);

    // Random traffic checked against the model
    for (int i = 0; i < 600; i++) begin
      logic r, s, rv;
      logic [31:0] rp;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 2) == 0);
      rv = ($urandom_range(0, 19) == 0);
      rp = $urandom;
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
      cyc(r, s, rv, rp);
    end
    cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
